ptw_read_arbiter: RTL

PTW_READ_ARBITER -- requirements
Module: ptw_read_arbiter

---
 rtl/ptw_arb_pkg.sv | 20 ++
 rtl/ptw_arb_rr.sv | 23 ++
 rtl/ptw_read_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ptw_arb_pkg.sv
// Shared types for the page-table-walker read arbiter.
// States, AXI response codes and the latched R-beat bundle.
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } ptw_arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } ptw_arb_rbeat_t;

endpackage

// File: rtl/ptw_arb_rr.sv
// Two-way round-robin grant for the PTW read arbiter.
// Purely combinational; the winner's index is valid when gnt_vld is high.
module ptw_arb_rr
  import ptw_arb_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt
);

  always_comb begin
    gnt_vld = req_0 | req_1;
    gnt     = 1'b0;
    unique case (1'b1)
      (req_0 && req_1):  gnt = ~last_grant;
      (!req_0 && req_1): gnt = 1'b1;
      default:           gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/ptw_read_arbiter.sv
// Shares one AXI-Lite read port between two MMU page-table walkers.
// Define PTW_ARB_TIMEOUT_EN to enable the master-read watchdog.
module ptw_read_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] araddr_0,
  input  logic        arvalid_0,
  output logic        arready_0,
  output logic [63:0] rdata_0,
  output logic [1:0]  rresp_0,
  output logic        rvalid_0,
  input  logic        rready_0,
  input  logic [63:0] araddr_1,
  input  logic        arvalid_1,
  output logic        arready_1,
  output logic [63:0] rdata_1,
  output logic [1:0]  rresp_1,
  output logic        rvalid_1,
  input  logic        rready_1,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  ptw_arb_state_t state, state_n;
  ptw_arb_rbeat_t rb_0, rb_1, beat;

  logic last_grant, g;
  logic gnt_vld, gnt;
  logic rready_g;
  logic ar_hs, ar_done;
  logic r_take, r_tmo, resp_done;
  logic tmo_hit;

  ptw_arb_rr u_rr (
    .req_0      (arvalid_0),
    .req_1      (arvalid_1),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  assign rready_g  = g ? rready_1 : rready_0;
  assign arready_0 = (state == IDLE) && gnt_vld && !gnt;
  assign arready_1 = (state == IDLE) && gnt_vld && gnt;

  assign rdata_0 = rb_0.data;
  assign rresp_0 = rb_0.resp;
  assign rdata_1 = rb_1.data;
  assign rresp_1 = rb_1.resp;

`ifdef PTW_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || ar_done) begin
      tmo_cnt <= '0;
    end else if (state == DATA && !rvalid) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    ar_hs     = 1'b0;
    ar_done   = 1'b0;
    r_take    = 1'b0;
    r_tmo     = 1'b0;
    resp_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          ar_hs   = 1'b1;
          state_n = ADDR;
        end
      end
      ADDR: begin
        // an R beat coinciding with arready is not ours yet: rready is low
        if (arready) begin
          ar_done = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (rvalid && rready) begin
          r_take  = 1'b1;
          state_n = RESP;
        end else if (tmo_hit) begin
          r_tmo   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rready_g) begin
          resp_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    beat.data = rdata;
    beat.resp = rresp;
    if (r_tmo) begin
      beat.data = '0;
      beat.resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      araddr     <= '0;
      g          <= 1'b0;
      last_grant <= 1'b1;
      rb_0       <= '0;
      rb_1       <= '0;
      rvalid_0   <= 1'b0;
      rvalid_1   <= 1'b0;
    end else begin
      if (ar_hs) begin
        g       <= gnt;
        araddr  <= gnt ? araddr_1 : araddr_0;
        arvalid <= 1'b1;
      end
      if (ar_done) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (r_take || r_tmo) begin
        rready <= 1'b0;
        if (g) begin
          rb_1     <= beat;
          rvalid_1 <= 1'b1;
        end else begin
          rb_0     <= beat;
          rvalid_0 <= 1'b1;
        end
      end
      if (resp_done) begin
        rvalid_0   <= 1'b0;
        rvalid_1   <= 1'b0;
        last_grant <= g;
      end
    end
  end

endmodule
